// File: rtl/pc_unit.sv
// Program counter at the head of fetch: sequential advance, stall hold, branch
// redirect with a one-entry pending-redirect buffer, and a RUN/HALTED state.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             halted,
  output logic             redirect_pending
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_VEC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    case (state_q)
      RUN: begin
        if (stall) begin
          // Keep the newest redirect seen while stalled; halt waits for the stall to clear.
          if (br_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = br_target;
          end
        end else begin
          pend_valid_d = 1'b0;
          if (br_taken) begin
            pc_d = br_target;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else if (halt) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + INC_W;
          end
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  assign pc               = pc_q;
  assign pc_plus          = pc_q + INC_W;
  assign halted           = (state_q == HALTED);
  assign redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a 16-bit default instance and an 8-bit
// instance with RESET_VEC=0xFC, INC=4 for wrap and parameter coverage.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        rst16 = 1'b0, stall16 = 1'b0, br16 = 1'b0, halt16 = 1'b0;
  logic [15:0] tgt16 = '0;
  logic [15:0] pc16, pcp16;
  logic        hlt16, pend16;

  // 8-bit instance
  logic        rst8 = 1'b0, stall8 = 1'b0, br8 = 1'b0, halt8 = 1'b0;
  logic [7:0]  tgt8 = '0;
  logic [7:0]  pc8, pcp8;
  logic        hlt8, pend8;

  pc_unit #(.WIDTH(16), .RESET_VEC(16'h0000), .INC(2)) dut16 (
    .clk(clk), .rst(rst16), .stall(stall16), .br_taken(br16), .br_target(tgt16),
    .halt(halt16), .pc(pc16), .pc_plus(pcp16), .halted(hlt16),
    .redirect_pending(pend16)
  );

  pc_unit #(.WIDTH(8), .RESET_VEC(8'hFC), .INC(4)) dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .br_taken(br8), .br_target(tgt8),
    .halt(halt8), .pc(pc8), .pc_plus(pcp8), .halted(hlt8),
    .redirect_pending(pend8)
  );

  typedef struct {
    logic        sel;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        halted;
    logic        pend;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic step(input logic sel, input logic r, input logic s, input logic b,
                      input logic [15:0] t, input logic h, input logic [15:0] epc,
                      input logic eh, input logic ep, input logic [15:0] epp,
                      input string nm);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      rst8 = r; stall8 = s; br8 = b; tgt8 = t[7:0]; halt8 = h;
    end else begin
      rst16 = r; stall16 = s; br16 = b; tgt16 = t; halt16 = h;
    end
    e.sel = sel; e.pc = epc; e.pc_plus = epp; e.halted = eh; e.pend = ep;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic chk(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: every cycle's registered outputs are compared against the oldest expectation.
  initial begin
    exp_t  e;
    string nm;
    logic [15:0] a_pc, a_pp;
    logic a_h, a_p;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.sel) begin
          a_pc = {8'h00, pc8}; a_pp = {8'h00, pcp8}; a_h = hlt8; a_p = pend8;
        end else begin
          a_pc = pc16; a_pp = pcp16; a_h = hlt16; a_p = pend16;
        end
        chk(nm, "pc", a_pc, e.pc);
        chk(nm, "pc_plus", a_pp, e.pc_plus);
        chk(nm, "halted", {15'b0, a_h}, {15'b0, e.halted});
        chk(nm, "pend", {15'b0, a_p}, {15'b0, e.pend});
        $display("txn %-12s dut%0d pc=%h pc_plus=%h halted=%0b pend=%0b", nm,
                 e.sel ? 8 : 16, a_pc, a_pp, a_h, a_p);
      end
    end
  end

  initial begin
    //    sel rst stl br  target    hlt  exp_pc    hlt pend  exp_pc_plus
    step(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, "reset");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 16'h0004, "seq1");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0004, 0, 0, 16'h0006, "seq2");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0006, 0, 0, 16'h0008, "seq3");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0008, 0, 0, 16'h000A, "seq4");
    step(0, 0, 0, 1, 16'h0010, 0, 16'h0010, 0, 0, 16'h0012, "jmp10");
    step(0, 0, 1, 0, 16'h0000, 0, 16'h0010, 0, 0, 16'h0012, "stall1");
    step(0, 0, 1, 1, 16'h0100, 0, 16'h0010, 0, 1, 16'h0012, "stall2_br");
    step(0, 0, 1, 0, 16'h0000, 0, 16'h0010, 0, 1, 16'h0012, "stall3");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0100, 0, 0, 16'h0102, "pend_apply");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0102, 0, 0, 16'h0104, "after_pend");
    step(0, 0, 1, 1, 16'h0200, 0, 16'h0102, 0, 1, 16'h0104, "ovw_200");
    step(0, 0, 1, 1, 16'h0300, 0, 16'h0102, 0, 1, 16'h0104, "ovw_300");
    step(0, 0, 0, 1, 16'h0400, 0, 16'h0400, 0, 0, 16'h0402, "br_wins");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0402, 0, 0, 16'h0404, "no_300");
    step(0, 0, 0, 1, 16'h0040, 1, 16'h0040, 0, 0, 16'h0042, "halt_supp");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0042, 0, 0, 16'h0044, "still_run");
    step(0, 0, 0, 1, 16'h0020, 0, 16'h0020, 0, 0, 16'h0022, "jmp20");
    step(0, 0, 0, 0, 16'h0000, 1, 16'h0020, 1, 0, 16'h0022, "halt");
    step(0, 0, 1, 1, 16'h0500, 0, 16'h0020, 1, 0, 16'h0022, "hlt_stbr");
    step(0, 0, 0, 1, 16'h0500, 0, 16'h0020, 1, 0, 16'h0022, "hlt_br");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0020, 1, 0, 16'h0022, "hlt_idle");
    step(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, "hlt_rst");
    step(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0002, "stall_halt");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 16'h0004, "after_sh");
    step(0, 0, 0, 1, 16'hFFFE, 0, 16'hFFFE, 0, 0, 16'h0000, "jmp_fffe");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, "wrap16");
    step(0, 0, 1, 1, 16'h0700, 0, 16'h0000, 0, 1, 16'h0002, "pend_700");
    step(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, "rst_pend");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 16'h0004, "no_700");
    step(1, 1, 0, 0, 16'h0000, 0, 16'h00FC, 0, 0, 16'h0000, "w8_reset");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, "w8_wrap");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0004, 0, 0, 16'h0008, "w8_seq");
    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit. It generalises the fixed 16-bit always-write PC register to configurable width, reset vector and increment step. It adds a stall hold, branch/jump redirect, a one-entry pending-redirect buffer that keeps redirects arriving during stalls, and a RUN/HALTED state machine. It sits at the head of the fetch stage, driving instruction-memory address and the sequential PC+step to decode.

Parameters:
WIDTH, 16, PC width in bits (>=4)
RESET_VEC, 0, PC value loaded on reset (WIDTH bits)
INC, 2, sequential increment added each advancing cycle (1..2^(WIDTH-1))

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC this cycle (hazard / memory wait)
br_taken  input  1  redirect request from execute (branch taken / jump)
br_target  input  WIDTH  redirect target, valid when br_taken=1
halt  input  1  halt instruction decoded at current pc
pc  output  WIDTH  current PC (registered)
pc_plus  output  WIDTH  pc+INC mod 2^WIDTH (combinational from pc)
halted  output  1  1 while in HALTED state (registered)
redirect_pending  output  1  pending-redirect buffer occupied (registered)

Behaviour:
- Reset (rst=1 at edge, overrides all other inputs, any state): pc<=RESET_VEC, state<=RUN, halted=0, pend_valid<=0, pend_target<=0. Outputs show reset values the cycle after the edge.
- State RUN, stall=1:
  - pc holds.
  - br_taken=1: pend_valid<=1, pend_target<=br_target. A newer redirect overwrites an older pending one.
  - br_taken=0: buffer unchanged.
  - halt is ignored.
- State RUN, stall=0, next-PC priority:
  1. br_taken=1 -> pc<=br_target
  2. else pend_valid=1 -> pc<=pend_target
  3. else halt=1 -> pc holds, state<=HALTED
  4. else pc<=pc+INC
- In every RUN stall=0 cycle pend_valid<=0. A redirect (1 or 2) suppresses halt: the halt is on a flushed path and the state stays RUN.
- State HALTED: pc, pend_valid and pend_target hold. stall, br_taken and halt are ignored. halted=1. Exit only via rst.
- Latency: one cycle from input to pc change. No combinational path from inputs to pc, halted or redirect_pending. pc_plus depends on pc only.
- Arithmetic: pc+INC is truncated to WIDTH bits. Wrap-around is legal and silent, e.g. WIDTH=16, INC=2, pc=0xFFFE -> 0x0000.
- Targets are not alignment-checked; br_target is loaded verbatim.
- Simultaneous br_taken and pending redirect with stall=0: br_taken wins and the buffer is cleared (the pending target is discarded).
- Reset asserted mid-stall with a redirect pending: the buffer is cleared and the pending target is never applied.

Test Plan:
- Reset/sequential: WIDTH=16, RESET_VEC=0, rst 1 cycle then 4 free cycles -> pc 0x0000,0x0002,0x0004,0x0006,0x0008; pc_plus=pc+2; halted=0.
- Stall + buffered redirect: pc=0x0010, stall=1 for 3 cycles, br_taken=1 target 0x0100 in the 2nd stall cycle -> pc stays 0x0010, redirect_pending=1. The cycle after stall drops, pc=0x0100 and redirect_pending=0.
- Overwrite/priority: stall=1, br_taken with target 0x0200 then 0x0300 -> pending 0x0300. With stall=0 and br_taken=1 target 0x0400 in the same cycle -> pc=0x0400; 0x0300 is never loaded.
- Halt: pc=0x0020, halt=1, stall=0 -> pc stays 0x0020, halted=1. Subsequent br_taken=1 target 0x0500 with stall toggling -> pc stays 0x0020. rst -> pc=RESET_VEC, halted=0.
- Halt suppressed: halt=1 and br_taken=1 target 0x0040 same cycle, stall=0 -> pc=0x0040, halted=0.
- Wrap/params: WIDTH=8, RESET_VEC=0xFC, INC=4 -> after reset pc=0xFC, then 0x00, then 0x04.
- Reset mid-operation: rst while redirect_pending=1 -> redirect_pending=0, pc=RESET_VEC, old target never appears.
